multi_cycle_controller: RTL and testbench

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

---
 rtl/multi_cycle_controller.sv | 206 ++++++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - multi-cycle MIPS-style control FSM with memory-wait timeout.
// Optional JUMP state is enabled by defining MULTI_CYCLE_CTRL_JUMP_EN.
module multi_cycle_controller #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       pc_en,
  output logic [3:0] state,
  output logic       err
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
    S_JUMP   = 4'd11,
`endif
    S_ERR    = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif
  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

  state_t     state_q, state_d;
  logic [7:0] wait_q;
  logic       err_q;
  logic       wait_state;
  logic       timed_out;

  // Raw Moore decode before the reset mask on the write enables.
  logic pc_write_raw, pc_write_cond_raw, ir_write_raw, mem_write_raw, reg_write_raw;

  assign wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timed_out  = (wait_q == TIMEOUT_CNT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)      state_d = S_DECODE;
        else if (timed_out) state_d = S_ERR;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
          OP_J:         state_d = S_JUMP;
`endif
          default:      state_d = S_ERR;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_ERR;
      end
      S_MEMRD: begin
        if (mem_ready)      state_d = S_MEMWB;
        else if (timed_out) state_d = S_ERR;
      end
      S_MEMWR: begin
        if (mem_ready)      state_d = S_FETCH;
        else if (timed_out) state_d = S_ERR;
      end
      S_MEMWB:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
      S_JUMP:   state_d = S_FETCH;
`endif
      S_ERR:    state_d = S_ERR;
      default:  state_d = S_ERR;
    endcase
  end

  // The wait counter only measures consecutive stalled cycles within one state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)          wait_q <= 8'd0;
      else if (wait_state && !mem_ready) wait_q <= wait_q + 8'd1;
      err_q <= err_q | (state_d == S_ERR);
    end
  end

  always_comb begin
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    ir_write_raw      = 1'b0;
    mem_write_raw     = 1'b0;
    reg_write_raw     = 1'b0;
    IorD              = 1'b0;
    MemRead           = 1'b0;
    MemtoReg          = 1'b0;
    ALUSrcA           = 1'b0;
    RegDst            = 1'b0;
    ALUSrcB           = 2'b00;
    ALUOp             = 2'b00;
    PCSource          = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead      = 1'b1;
        ALUSrcB      = 2'b01;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        reg_write_raw = 1'b1;
        MemtoReg      = 1'b1;
      end
      S_MEMWR: begin
        mem_write_raw = 1'b1;
        IorD          = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        RegDst        = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA           = 1'b1;
        ALUOp             = 2'b01;
        pc_write_cond_raw = 1'b1;
        PCSource          = 2'b01;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
      S_JUMP: begin
        pc_write_raw = 1'b1;
        PCSource     = 2'b10;
      end
`endif
      default: ;
    endcase
  end

  // Reset kills writes in the same cycle so an aborted instruction commits nothing.
  assign PCWrite     = pc_write_raw & ~rst;
  assign PCWriteCond = pc_write_cond_raw & ~rst;
  assign IRWrite     = ir_write_raw & ~rst;
  assign MemWrite    = mem_write_raw & ~rst;
  assign RegWrite    = reg_write_raw & ~rst;
  assign pc_en       = PCWrite | (PCWriteCond & zero);
  assign state       = state_q;
  assign err         = err_q;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb/tb_multi_cycle_controller.sv - randomized instruction-level bench for multi_cycle_controller.
module tb_multi_cycle_controller;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       pc_en;
  logic [3:0] state;
  logic       err;

  int checks = 0;
  int errors = 0;
  int zero_mode = -1;

  multi_cycle_controller #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .pc_en(pc_en), .state(state), .err(err)
  );

  always #5 clk = ~clk;

  logic [17:0] ctrl_vec;
  assign ctrl_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA,
                     RegWrite, RegDst, ALUSrcB, ALUOp, PCSource, pc_en, err};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Control table written straight from the per-state output rules.
  function automatic logic [17:0] exp_ctrl(input int st, input bit mr, input bit z);
    bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, m2r = 0, irw = 0, asa = 0, rw = 0, rd = 0;
    bit [1:0] asb = 0, aop = 0, psrc = 0;
    case (st)
      0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      9:  begin asa = 1; asb = 2'b10; end
      10: rw = 1;
      11: begin pcw = 1; psrc = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, asb, aop, psrc,
            pcw | (pcwc & z), (st == 15)};
  endfunction

  task automatic step(input int st, input bit mr);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = mr;
    zero = (zero_mode < 0) ? 1'($urandom_range(0, 1)) : zero_mode[0];
    #1;
    check("state", 32'(state), 32'(st));
    check("ctrl", 32'(ctrl_vec), 32'(exp_ctrl(st, mr, zero)));
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      rst = 1'b1;
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check("rst_wen", 32'({PCWrite, PCWriteCond, IRWrite, MemWrite, RegWrite}), 32'd0);
      if (i > 0) begin
        check("rst_state", 32'(state), 32'd0);
        check("rst_err", 32'(err), 32'd0);
      end
    end
  endtask

  // A memory phase stalls w cycles; the stall that lands on TIMEOUT with no ready faults.
  task automatic mem_phase(input int st, input int w, output bit timed_out);
    timed_out = 0;
    for (int i = 0; i <= w; i++) begin
      step(st, i == w);
      if (i != w && i == TIMEOUT) begin
        timed_out = 1;
        break;
      end
    end
  endtask

  task automatic err_tail();
    repeat (3) step(15, 1'($urandom_range(0, 1)));
    do_reset(2);
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    bit to;
    opcode = op;
    mem_phase(0, fw, to);
    if (to) begin err_tail(); return; end
    step(1, 1'($urandom_range(0, 1)));
    case (op)
      6'b000000: begin step(6, 1'($urandom_range(0, 1))); step(7, 1'($urandom_range(0, 1))); end
      6'b100011: begin
        step(2, 1'($urandom_range(0, 1)));
        mem_phase(3, mw, to);
        if (to) err_tail(); else step(4, 1'($urandom_range(0, 1)));
      end
      6'b101011: begin
        step(2, 1'($urandom_range(0, 1)));
        mem_phase(5, mw, to);
        if (to) err_tail();
      end
      6'b000100: step(8, 1'($urandom_range(0, 1)));
      6'b001000: begin step(9, 1'($urandom_range(0, 1))); step(10, 1'($urandom_range(0, 1))); end
`ifdef MULTI_CYCLE_CTRL_JUMP_EN
      6'b000010: step(11, 1'($urandom_range(0, 1)));
`endif
      default: begin step(15, 1'($urandom_range(0, 1))); err_tail(); end
    endcase
  endtask

  function automatic int pick_wait();
    if ($urandom_range(0, 7) == 0) return TIMEOUT + int'($urandom_range(0, 1));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [5:0] ops [8];
    bit to;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b111111; ops[7] = 6'b000000;
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'd0; zero = 1'b0;
    do_reset(2);
    run_instr(6'b000000, 0, 0);
    run_instr(6'b100011, 0, 3);
    zero_mode = 1; run_instr(6'b000100, 0, 0);
    zero_mode = 0; run_instr(6'b000100, 1, 0);
    zero_mode = -1;
    run_instr(6'b000000, TIMEOUT, 0);
    run_instr(6'b000000, TIMEOUT + 1, 0);
    run_instr(6'b100011, 0, TIMEOUT + 1);
    run_instr(6'b101011, 0, TIMEOUT);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b001000, 2, 0);

    // Reset landing mid-store must suppress the write in that very cycle.
    opcode = 6'b101011;
    mem_phase(0, 0, to);
    step(1, 1'b1);
    step(2, 1'b1);
    step(5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    mem_ready = 1'b0;
    #1;
    check("rst_memwr", 32'(MemWrite), 32'd0);
    @(posedge clk);
    #1;
    check("rst_memwr_state", 32'(state), 32'd0);

    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 7)];
      if (n % 8 == 7) op = 6'($urandom_range(0, 63));
      run_instr(op, pick_wait(), pick_wait());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
